// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - ALU instruction sequencer with memory-wait handling; optional read timeout under `define ALU_SEQ_TIMEOUT_EN
module alu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [7:0]  instr_opcode,
  input  logic [23:0] instr_data,
  input  logic        ValidMemData,
  output logic        instr_ready,
  output logic [7:0]  ALU_Sel,
  output logic [23:0] DecoderData,
  output logic        busy,
  output logic        illegal_op,
  output logic        mem_timeout,
  output logic [7:0]  last_wait
);

  // Selection codes reserved for the sequencer itself, and opcode classes.
  localparam logic [7:0] SEL_WAIT       = 8'd255;
  localparam logic [7:0] SEL_ENDWAIT    = 8'd254;
  localparam logic [7:0] OP_LEGAL_LIMIT = 8'd50;
  localparam logic [7:0] OP_POP         = 8'd35;
  localparam logic [7:0] OP_LD          = 8'd36;
  localparam logic [7:0] OP_LDI         = 8'd37;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
`endif

  // Catch an out-of-range timeout at elaboration rather than in silicon.
  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("alu_sequencer: TIMEOUT_CYCLES must be within 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_MEM = 2'd2,
    S_ENDWAIT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_instr_ready;
  logic [7:0]  r_alu_sel;
  logic [23:0] r_dec_data;
  logic        r_busy;
  logic        r_illegal_op;
  logic        r_mem_timeout;
  logic [7:0]  r_last_wait;
  logic [7:0]  r_wait_cnt;

  logic        w_instr_ready;
  logic [7:0]  w_alu_sel;
  logic [23:0] w_dec_data;
  logic        w_busy;
  logic        w_illegal_op;
  logic        w_mem_timeout;
  logic [7:0]  w_last_wait;
  logic [7:0]  w_wait_cnt;
  logic [7:0]  w_cnt_inc;
  logic        w_handshake;

  // The ready flag is itself registered, so the handshake uses what the decoder saw.
  assign w_handshake = instr_valid & r_instr_ready;

  // Wait count including the current cycle, saturating so it never wraps.
  assign w_cnt_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : (r_wait_cnt + 8'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and the values every output register takes on the next edge.
  always_comb begin
    w_next_state  = r_state;
    w_alu_sel     = SEL_WAIT;
    w_dec_data    = r_dec_data;
    w_illegal_op  = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
    w_mem_timeout = r_mem_timeout;
`else
    w_mem_timeout = 1'b0;
`endif
    w_last_wait   = r_last_wait;
    w_wait_cnt    = r_wait_cnt;

    case (r_state)
      S_IDLE: begin
        w_dec_data = 24'd0;
        if (w_handshake) begin
          if (instr_opcode < OP_LEGAL_LIMIT) begin
            w_next_state = S_ISSUE;
            w_alu_sel    = instr_opcode;
            w_dec_data   = instr_data;
          end else begin
            // Includes the internal codes 254/255: the decoder may never issue them.
            w_illegal_op = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        // r_alu_sel still holds the opcode being issued.
        if (r_alu_sel inside {OP_POP, OP_LD, OP_LDI}) begin
          w_next_state = S_WAIT_MEM;
          w_wait_cnt   = 8'd0;
        end else begin
          w_next_state = S_IDLE;
          w_dec_data   = 24'd0;
        end
      end

      S_WAIT_MEM: begin
        if (ValidMemData) begin
          // Data arriving on the timeout cycle still counts as a good read.
          w_next_state = S_ENDWAIT;
          w_alu_sel    = SEL_ENDWAIT;
          w_last_wait  = w_cnt_inc;
          w_wait_cnt   = 8'd0;
`ifdef ALU_SEQ_TIMEOUT_EN
        end else if (w_cnt_inc >= TIMEOUT_LIM) begin
          w_next_state  = S_ENDWAIT;
          w_alu_sel     = SEL_ENDWAIT;
          w_mem_timeout = 1'b1;
          w_last_wait   = TIMEOUT_LIM;
          w_wait_cnt    = 8'd0;
`endif
        end else begin
          w_wait_cnt = w_cnt_inc;
        end
      end

      S_ENDWAIT: begin
        w_next_state = S_IDLE;
        w_dec_data   = 24'd0;
        w_wait_cnt   = 8'd0;
      end

      default: begin
        w_next_state = S_IDLE;
        w_dec_data   = 24'd0;
        w_wait_cnt   = 8'd0;
      end
    endcase

    w_busy        = (w_next_state != S_IDLE);
    w_instr_ready = (w_next_state == S_IDLE);
  end

  // Output and bookkeeping registers; ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_ready <= 1'b0;
      r_alu_sel     <= SEL_WAIT;
      r_dec_data    <= 24'd0;
      r_busy        <= 1'b0;
      r_illegal_op  <= 1'b0;
      r_mem_timeout <= 1'b0;
      r_last_wait   <= 8'd0;
      r_wait_cnt    <= 8'd0;
    end else begin
      r_instr_ready <= w_instr_ready;
      r_alu_sel     <= w_alu_sel;
      r_dec_data    <= w_dec_data;
      r_busy        <= w_busy;
      r_illegal_op  <= w_illegal_op;
      r_mem_timeout <= w_mem_timeout;
      r_last_wait   <= w_last_wait;
      r_wait_cnt    <= w_wait_cnt;
    end
  end

  assign instr_ready = r_instr_ready;
  assign ALU_Sel     = r_alu_sel;
  assign DecoderData = r_dec_data;
  assign busy        = r_busy;
  assign illegal_op  = r_illegal_op;
  assign mem_timeout = r_mem_timeout;
  assign last_wait   = r_last_wait;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic [7:0]  instr_opcode = 8'd0;
  logic [23:0] instr_data = 24'd0;
  logic        ValidMemData = 1'b0;
  logic        instr_ready;
  logic [7:0]  ALU_Sel;
  logic [23:0] DecoderData;
  logic        busy;
  logic        illegal_op;
  logic        mem_timeout;
  logic [7:0]  last_wait;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  exp_last_wait = 8'd0;
  logic        exp_timeout = 1'b0;

  alu_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_opcode (instr_opcode),
    .instr_data   (instr_data),
    .ValidMemData (ValidMemData),
    .instr_ready  (instr_ready),
    .ALU_Sel      (ALU_Sel),
    .DecoderData  (DecoderData),
    .busy         (busy),
    .illegal_op   (illegal_op),
    .mem_timeout  (mem_timeout),
    .last_wait    (last_wait)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"},     32'(ALU_Sel), 32'd255);
    chk({tag, "_data"},    32'(DecoderData), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_ready"},   32'(instr_ready), 32'd1);
    chk({tag, "_lastw"},   32'(last_wait), 32'(exp_last_wait));
    chk({tag, "_timeout"}, 32'(mem_timeout), 32'(exp_timeout));
  endtask

  // Assert reset mid-cycle, check the asynchronous response, then release.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    exp_last_wait = 8'd0;
    exp_timeout   = 1'b0;
    chk({tag, "_rst_sel"},   32'(ALU_Sel), 32'd255);
    chk({tag, "_rst_data"},  32'(DecoderData), 32'd0);
    chk({tag, "_rst_busy"},  32'(busy), 32'd0);
    chk({tag, "_rst_ill"},   32'(illegal_op), 32'd0);
    chk({tag, "_rst_to"},    32'(mem_timeout), 32'd0);
    chk({tag, "_rst_lastw"}, 32'(last_wait), 32'd0);
    chk({tag, "_rst_ready"}, 32'(instr_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk({tag, "_rel_ready0"}, 32'(instr_ready), 32'd0);
    tick();
    chk_idle({tag, "_rel"});
  endtask

  // One instruction through the reference rules: illegal -> pulse only;
  // plain op -> [op]; memory op -> [op, 255 x lat, 254]. lat==0 means no data (timeout).
  task automatic do_instr(input logic [7:0] op, input logic [23:0] data, input int lat);
    int n;
    instr_valid  = 1'b1;
    instr_opcode = op;
    instr_data   = data;
    tick();
    instr_valid  = 1'b0;
    instr_opcode = 8'($urandom);
    instr_data   = 24'($urandom);
    if (op >= 8'd50) begin
      chk("illegal_pulse", 32'(illegal_op), 32'd1);
      chk("illegal_sel",   32'(ALU_Sel), 32'd255);
      chk("illegal_busy",  32'(busy), 32'd0);
      tick();
      chk("illegal_end",   32'(illegal_op), 32'd0);
      chk_idle("illegal_idle");
      return;
    end
    chk("issue_sel",   32'(ALU_Sel), 32'(op));
    chk("issue_data",  32'(DecoderData), 32'(data));
    chk("issue_busy",  32'(busy), 32'd1);
    chk("issue_ready", 32'(instr_ready), 32'd0);
    chk("issue_ill",   32'(illegal_op), 32'd0);
    if (op == 8'd35 || op == 8'd36 || op == 8'd37) begin
      n = (lat == 0) ? TO : lat;
      ValidMemData = 1'($urandom_range(0, 1));
      for (int i = 1; i <= n; i++) begin
        tick();
        ValidMemData = (lat != 0 && i == lat);
        chk("wait_sel",  32'(ALU_Sel), 32'd255);
        chk("wait_data", 32'(DecoderData), 32'(data));
        chk("wait_busy", 32'(busy), 32'd1);
      end
      tick();
      ValidMemData = 1'b0;
      if (lat == 0) begin
        exp_timeout   = 1'b1;
        exp_last_wait = 8'(TO);
      end else begin
        exp_last_wait = (lat > 255) ? 8'd255 : 8'(lat);
      end
      chk("endwait_sel",   32'(ALU_Sel), 32'd254);
      chk("endwait_lastw", 32'(last_wait), 32'(exp_last_wait));
      chk("endwait_to",    32'(mem_timeout), 32'(exp_timeout));
      chk("endwait_busy",  32'(busy), 32'd1);
    end
    tick();
    chk_idle("after_instr");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [3];
    logic [7:0] exp_seq [6];
    logic [7:0] op;
    int         idx;
    logic       rdy;

    #2;
    apply_reset("init");

    // Simple op right after reset.
    do_instr(8'd3, 24'h000010, 0);

    // POP with data on the fourth wait cycle.
    do_instr(8'd35, 24'h00ABCD, 4);

    // Rejected opcodes, including an internal code.
    do_instr(8'd60, 24'h123456, 0);
    do_instr(8'd254, 24'h654321, 0);
    do_instr(8'd50, 24'h000001, 0);
    do_instr(8'd49, 24'h000002, 0);

    // Memory data outside a read is ignored.
    ValidMemData = 1'b1;
    tick();
    tick();
    ValidMemData = 1'b0;
    chk_idle("stray_valid");

    // Minimum wait.
    do_instr(8'd37, 24'hFFFFFF, 1);

`ifdef ALU_SEQ_TIMEOUT_EN
    do_instr(8'd36, 24'h0000AA, TO);
    do_instr(8'd36, 24'h0000BB, 0);
    do_instr(8'd4, 24'h0000CC, 0);
`else
    do_instr(8'd36, 24'h0000AA, 20);
    do_instr(8'd36, 24'h0000BB, 300);
`endif

    // Reset during a read abandons it without an ENDWAIT.
    instr_valid  = 1'b1;
    instr_opcode = 8'd37;
    instr_data   = 24'h00C0DE;
    tick();
    instr_valid  = 1'b0;
    chk("rst_mid_issue", 32'(ALU_Sel), 32'd37);
    tick();
    tick();
    chk("rst_mid_wait", 32'(ALU_Sel), 32'd255);
    #2;
    apply_reset("midread");
    do_instr(8'd7, 24'h000777, 0);

    // Back-to-back stream: the decoder holds each op until it is taken.
    ops[0] = 8'd17; ops[1] = 8'd19; ops[2] = 8'd21;
    exp_seq[0] = 8'd17; exp_seq[1] = 8'd255; exp_seq[2] = 8'd19;
    exp_seq[3] = 8'd255; exp_seq[4] = 8'd21; exp_seq[5] = 8'd255;
    idx = 0;
    instr_valid  = 1'b1;
    instr_opcode = ops[0];
    instr_data   = 24'h000017;
    for (int c = 0; c < 6; c++) begin
      rdy = instr_ready;
      tick();
      if (rdy && instr_valid) begin
        idx++;
        if (idx < 3) begin
          instr_opcode = ops[idx];
          instr_data   = 24'(ops[idx]);
        end else begin
          instr_valid = 1'b0;
        end
      end
      chk("stream_sel", 32'(ALU_Sel), 32'(exp_seq[c]));
    end
    chk("stream_count", 32'(idx), 32'd3);
    chk_idle("stream_end");

    // Randomized mix of plain, memory and illegal instructions.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       op = 8'($urandom_range(35, 37));
        1:       op = 8'($urandom_range(50, 255));
        default: op = 8'($urandom_range(0, 49));
      endcase
      do_instr(op, 24'($urandom), int'($urandom_range(1, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT_MEM cycles before forced abort (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_valid  input  1  decoder presents an instruction.
REQ-005 SHALL have port instr_opcode  input  8  ALU selection code from decoder.
REQ-006 SHALL have port instr_data  input  24  immediate/address field from decoder.
REQ-007 SHALL have port ValidMemData  input  1  memory controller read data valid.
REQ-008 SHALL have port instr_ready  output  1  sequencer accepts an instruction this cycle.
REQ-009 SHALL have port ALU_Sel  output  8  registered selection driven to ALU.
REQ-010 SHALL have port DecoderData  output  24  registered data field driven to ALU.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port illegal_op  output  1  one-cycle pulse on rejected opcode.
REQ-013 SHALL have port mem_timeout  output  1  sticky flag, memory read aborted by timeout.
REQ-014 SHALL have port last_wait  output  8  WAIT_MEM cycle count of the most recent completed read.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_MEM, ENDWAIT; all outputs registered.
REQ-016 SHALL drive instr_ready=1 only in IDLE; handshake = instr_valid & instr_ready at a rising edge.
REQ-017 IDLE SHALL drive ALU_Sel=8'd255 (WAIT, no side effects) and DecoderData=0.
REQ-018 On handshake with opcode 0..49 SHALL capture opcode/data, enter ISSUE; ALU_Sel=opcode, DecoderData=instr_data in the following cycle.
REQ-019 On handshake with opcode 50..255 (incl. internal 254/255) SHALL stay in IDLE, drop the instruction, pulse illegal_op for exactly one cycle.
REQ-020 ISSUE SHALL last exactly one cycle; opcode 35 (POP), 36 (LD), 37 (LDI) -> WAIT_MEM, any other -> IDLE (throughput one instruction per 2 cycles).
REQ-021 WAIT_MEM SHALL drive ALU_Sel=8'd255, hold DecoderData, increment 8-bit wait counter each cycle, saturating at 255.
REQ-022 WAIT_MEM SHALL exit to ENDWAIT on the first cycle ValidMemData=1, loading last_wait with the counter value including that cycle (minimum 1).
REQ-023 ENDWAIT SHALL drive ALU_Sel=8'd254 for exactly one cycle, then -> IDLE; wait counter cleared.
REQ-024 ValidMemData outside WAIT_MEM SHALL be ignored.
REQ-025 instr_valid while busy SHALL be ignored; decoder holds the instruction until instr_ready.
REQ-026 ValidMemData and timeout in the same cycle: data wins, mem_timeout not set.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, ALU_Sel=8'd255, DecoderData=0, busy=0, illegal_op=0, mem_timeout=0, last_wait=0, wait counter=0, instr_ready=0.
REQ-028 instr_ready SHALL rise on the first rising edge after rst_n deasserts; reset mid-read SHALL abandon the read with no ENDWAIT issued.

Configuration
REQ-029 Macro ALU_SEQ_TIMEOUT_EN defined: WAIT_MEM with counter reaching TIMEOUT_CYCLES without ValidMemData SHALL go to ENDWAIT, set mem_timeout (cleared only by reset), load last_wait=TIMEOUT_CYCLES.
REQ-030 Macro ALU_SEQ_TIMEOUT_EN undefined: WAIT_MEM SHALL wait indefinitely; mem_timeout tied to 0.

Verification
REQ-031 Reset release, instr_valid=1 opcode 3 data 0x000010 -> ALU_Sel=3, DecoderData=0x000010 for one cycle, then 255; busy high one cycle.
REQ-032 Opcode 35 accepted, ValidMemData asserted 4th WAIT_MEM cycle -> ALU_Sel sequence 35,255,255,255,255,254,255; last_wait=4.
REQ-033 Opcode 60 then opcode 254 presented -> each rejected, illegal_op one-cycle pulse each, ALU_Sel stays 255, no ISSUE.
REQ-034 With ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, opcode 36, no ValidMemData -> ENDWAIT after 8 WAIT_MEM cycles, mem_timeout=1, last_wait=8; ValidMemData on cycle 8 instead -> mem_timeout=0.
REQ-035 rst_n pulsed low during WAIT_MEM of opcode 37 -> outputs at reset values asynchronously, no 254 emitted, next instruction accepted normally.
REQ-036 Back-to-back instr_valid stream of opcodes 17,19,21 -> issued in order one per 2 cycles, none lost or duplicated.
